led_trace_capture: RTL and testbench



---
 rtl/led_trace_capture.sv | 146 ++++++++++++++
 tb/tb_led_trace_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_trace_capture.sv
// led_trace_capture: samples a generated circuit's LED wires, records every
// change as a {timestamp, led_value} event in a small show-ahead FIFO, and
// presents the events on a ready/valid read port.
//
// Read port handshake: out_valid is high whenever the FIFO holds an entry.
// out_data is the head entry while out_valid is high. An entry is consumed
// on a rising edge where out_valid && out_ready. out_valid does not depend
// on out_ready, and out_data is driven to zero while the FIFO is empty.
module led_trace_capture #(
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 4,
    parameter int TS_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            led_in,
    input  logic                        enable,
    input  logic                        out_ready,
    input  logic                        clear_ovf,
    output logic                        out_valid,
    output logic [TS_WIDTH+WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TS_WIDTH + WIDTH;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]    sync1;
    logic [WIDTH-1:0]    sync2;
    logic [WIDTH-1:0]    prev;
    logic                primed;
    logic [1:0]          boot_cnt;
    logic [TS_WIDTH-1:0] ts;

    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    logic                baseline;
    logic                change;
    logic                push;
    logic                pop;
    logic                full;
    logic                accept;
    logic                drop;

    // Event detection and FIFO handshake decisions for the current cycle
    always_comb begin
        baseline = !primed && (boot_cnt == 2'd2);
        change   = primed && enable && (sync2 != prev);
        push     = baseline || change;
        pop      = out_valid && out_ready;
        full     = (count == FULL_COUNT);
        accept   = push && (!full || pop);
        drop     = push && full && !pop;
    end

    // Show-ahead head entry; zero while empty so the port is never X
    always_comb begin
        out_valid = (count != '0);
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    // Two-flop synchronizer for the asynchronous LED wires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= led_in;
            sync2 <= sync1;
        end
    end

    // Priming after reset: the third edge loads prev and emits the baseline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boot_cnt <= 2'd0;
            primed   <= 1'b0;
            prev     <= '0;
        end else begin
            if (!primed) begin
                if (boot_cnt == 2'd2) begin
                    primed <= 1'b1;
                end else begin
                    boot_cnt <= boot_cnt + 1'b1;
                end
            end
            // prev follows sync2 even while enable is low, so gated changes are lost
            if (primed || baseline) begin
                prev <= sync2;
            end
        end
    end

    // Free-running timestamp; wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    // FIFO storage; contents need no reset because out_data is masked when empty
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {ts, sync2};
        end
    end

    // FIFO pointers and occupancy; a pop frees room for a push in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (!accept && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as clear_ovf keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_trace_capture.sv
// Bench for led_trace_capture: a behavioural model built from the LED value
// seen at each edge, a per-cycle compare process, directed scenarios with
// literal expectations, and a randomized phase.
module tb_led_trace_capture;

    localparam int WIDTH    = 2;
    localparam int DEPTH    = 4;
    localparam int TS_WIDTH = 16;
    localparam int EW       = TS_WIDTH + WIDTH;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [WIDTH-1:0]       led_in;
    logic                   enable;
    logic                   out_ready;
    logic                   clear_ovf;
    logic                   out_valid;
    logic [EW-1:0]          out_data;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model state: edges since reset release, LED value seen at each edge
    logic [EW-1:0]    exp_q[$];
    logic [WIDTH-1:0] led_hist[$];
    int               m_n   = 0;
    logic             m_ovf = 1'b0;
    bit               m_ev;
    bit               m_pop;
    bit               m_drop;
    int               m_sz;
    logic [EW-1:0]    m_ent;

    led_trace_capture #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .led_in(led_in), .enable(enable),
        .out_ready(out_ready), .clear_ovf(clear_ovf),
        .out_valid(out_valid), .out_data(out_data), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: at edge n (n=1 first after release) the value compared is the LED
    // seen at edge n-2 against edge n-3; the event carries timestamp n-1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            led_hist.delete();
            m_n   = 0;
            m_ovf = 1'b0;
        end else begin
            m_n = m_n + 1;
            led_hist.push_back(led_in);
            m_ev = 1'b0;
            m_ent = '0;
            if (m_n == 3) begin
                m_ev  = 1'b1;
                m_ent = {TS_WIDTH'(m_n - 1), led_hist[0]};
            end else if (m_n > 3 && enable && (led_hist[m_n-3] != led_hist[m_n-4])) begin
                m_ev  = 1'b1;
                m_ent = {TS_WIDTH'(m_n - 1), led_hist[m_n-3]};
            end
            m_sz   = exp_q.size();
            m_pop  = (m_sz > 0) && out_ready;
            m_drop = m_ev && (m_sz == DEPTH) && !m_pop;
            if (m_pop) void'(exp_q.pop_front());
            if (m_ev && !m_drop) exp_q.push_back(m_ent);
            if (m_drop) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("count", count, exp_q.size());
            chk("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : '0);
            chk("overflow", overflow, m_ovf);
        end
    end

    logic [WIDTH-1:0] first_val;
    logic [TS_WIDTH-1:0] first_ts;

    initial begin
        rst       = 1'b1;
        led_in    = 2'b01;
        enable    = 1'b1;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;

        // Reset state and baseline
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_baseline_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("baseline_data", out_data, {16'd2, 2'b01});
        chk("baseline_count", count, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Single change just before the edge that samples ts=20
        while (m_n < 20) @(negedge clk);
        led_in = 2'b10;
        repeat (2) @(negedge clk);
        chk("sync_delay_no_event", out_valid, 1'b0);
        @(negedge clk);
        chk("change_data", out_data, {16'd22, 2'b10});
        chk("change_count", count, 1);
        repeat (5) @(negedge clk);
        chk("no_duplicate", count, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Enable gating
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            led_in = ~led_in;
            repeat (3) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("gated_count", count, 0);
        chk("gated_ovf", overflow, 1'b0);
        led_in = ~led_in;
        repeat (3) @(negedge clk);
        chk("after_gate_count", count, 1);
        repeat (3) @(negedge clk);
        chk("after_gate_single", count, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Fill and overflow: five changes, four kept
        for (int i = 0; i < 5; i++) begin
            led_in = ~led_in;
            if (i == 0) begin
                first_val = led_in;
                first_ts  = TS_WIDTH'(m_n + 2);
            end
            repeat (4) @(negedge clk);
        end
        chk("full_count", count, 4);
        chk("full_ovf", overflow, 1'b1);
        chk("full_head", out_data, {first_ts, first_val});
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);

        // Push into a full FIFO in the same cycle as a pop
        led_in = ~led_in;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("full_pop_count", count, 4);
        chk("full_pop_ovf", overflow, 1'b0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        chk("drained", count, 0);

        // Reset in the middle of operation
        for (int i = 0; i < 3; i++) begin
            led_in = ~led_in;
            repeat (4) @(negedge clk);
        end
        chk("pre_reset_count", count, 3);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_count", count, 0);
        chk("async_rst_ovf", overflow, 1'b0);
        @(negedge clk);
        led_in = 2'b10;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rebaseline_data", out_data, {16'd2, 2'b10});

        // Randomized traffic with one asynchronous reset pulse
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) led_in = WIDTH'($urandom_range(0, 3));
            enable    = ($urandom_range(0, 7) != 0);
            out_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 1) == 0);
            clear_ovf = ($urandom_range(0, 15) == 0);
            if (i == 1500) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
